// File: rtl/ball_motion_pkg.sv
// Shared types and default playfield constants for the Pong ball engine.
package ball_motion_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    PLAY,
    OUT
  } ball_state_t;

  localparam int unsigned DEF_X_W          = 10;
  localparam int unsigned DEF_Y_W          = 10;
  localparam int unsigned DEF_SPEED_W      = 3;
  localparam int unsigned DEF_X_LIMIT      = 640;
  localparam int unsigned DEF_Y_LIMIT      = 480;
  localparam int unsigned DEF_BALL_SIZE    = 8;
  localparam int unsigned DEF_SERVE_FRAMES = 60;

endpackage

// File: rtl/ball_motion_if.sv
// Ball engine connection: frame timing and paddle inputs, ball state and score outputs.
interface ball_motion_if #(
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 10,
  parameter int unsigned SPEED_W = 3
) ();

  logic               frame_tick;
  logic               serve_req;
  logic [SPEED_W-1:0] speed_sel;
  logic               paddle_hit_l;
  logic               paddle_hit_r;
  logic [X_W-1:0]     ball_x;
  logic [Y_W-1:0]     ball_y;
  logic               x_dir;
  logic               y_dir;
  logic               in_play;
  logic               score_l;
  logic               score_r;

  modport master (
    input  frame_tick, serve_req, speed_sel, paddle_hit_l, paddle_hit_r,
    output ball_x, ball_y, x_dir, y_dir, in_play, score_l, score_r
  );

  modport slave (
    output frame_tick, serve_req, speed_sel, paddle_hit_l, paddle_hit_r,
    input  ball_x, ball_y, x_dir, y_dir, in_play, score_l, score_r
  );

endinterface

// File: rtl/ball_motion_axis_step.sv
// One-axis ball step: advances pos by step in dir; BOUNCE clamps and reverses at the
// edges, otherwise an out-of-range step holds pos and raises exit_flag.
module ball_axis_step #(
  parameter int unsigned W      = 10,
  parameter int unsigned STEP_W = 3,
  parameter bit          BOUNCE = 1'b0
) (
  input  logic [W-1:0]      pos,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [W:0]        max_pos,
  output logic [W-1:0]      next_pos,
  output logic              next_dir,
  output logic              exit_flag
);

  logic [W:0] pos_e;
  logic [W:0] step_e;
  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    pos_e     = {1'b0, pos};
    step_e    = (W+1)'(step);
    sum       = pos_e + step_e;
    diff      = pos_e - step_e;
    next_pos  = pos;
    next_dir  = dir;
    exit_flag = 1'b0;
    if (dir) begin
      if (sum > max_pos) begin
        if (BOUNCE) begin
          next_pos = max_pos[W-1:0];
          next_dir = 1'b0;
        end else begin
          exit_flag = 1'b1;
        end
      end else begin
        next_pos = sum[W-1:0];
      end
    end else begin
      if (pos_e < step_e) begin
        if (BOUNCE) begin
          next_pos = '0;
          next_dir = 1'b1;
        end else begin
          exit_flag = 1'b1;
        end
      end else begin
        next_pos = diff[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Frame-stepped Pong ball engine: serve sequencing, wall bounce, paddle deflection
// and miss/score detection. All outputs are registered.
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int unsigned X_W          = DEF_X_W,
  parameter int unsigned Y_W          = DEF_Y_W,
  parameter int unsigned SPEED_W      = DEF_SPEED_W,
  parameter int unsigned X_LIMIT      = DEF_X_LIMIT,
  parameter int unsigned Y_LIMIT      = DEF_Y_LIMIT,
  parameter int unsigned BALL_SIZE    = DEF_BALL_SIZE,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic          clk,
  input  logic          reset,
  ball_motion_if.master bus
);

  localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [X_W:0]     X_MAX    = (X_W+1)'(X_LIMIT - BALL_SIZE);
  localparam logic [Y_W:0]     Y_MAX    = (Y_W+1)'(Y_LIMIT - BALL_SIZE);
  localparam logic [X_W-1:0]   XC       = X_W'((X_LIMIT - BALL_SIZE) / 2);
  localparam logic [Y_W-1:0]   YC       = Y_W'((Y_LIMIT - BALL_SIZE) / 2);

  ball_state_t        state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               x_dir_q, x_dir_d;
  logic               y_dir_q, y_dir_d;
  logic [SPEED_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               srv_x_q, srv_x_d;
  logic               srv_y_q, srv_y_d;
  logic               in_play_q, in_play_d;
  logic               score_l_q, score_l_d;
  logic               score_r_q, score_r_d;

  logic               x_dir_hit;
  logic [X_W-1:0]     x_np;
  logic               x_nd;
  logic               x_exit;
  logic [Y_W-1:0]     y_np;
  logic               y_nd;
  logic               y_exit;

  // Only a hit against the current direction of travel deflects the ball.
  always_comb begin
    x_dir_hit = x_dir_q;
    if (bus.paddle_hit_l && !x_dir_q) begin
      x_dir_hit = 1'b1;
    end else if (bus.paddle_hit_r && x_dir_q) begin
      x_dir_hit = 1'b0;
    end
  end

  ball_axis_step #(.W(X_W), .STEP_W(SPEED_W), .BOUNCE(1'b0)) u_x_axis (
    .pos(x_q), .dir(x_dir_hit), .step(step_q), .max_pos(X_MAX),
    .next_pos(x_np), .next_dir(x_nd), .exit_flag(x_exit)
  );

  ball_axis_step #(.W(Y_W), .STEP_W(SPEED_W), .BOUNCE(1'b1)) u_y_axis (
    .pos(y_q), .dir(y_dir_q), .step(step_q), .max_pos(Y_MAX),
    .next_pos(y_np), .next_dir(y_nd), .exit_flag(y_exit)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    x_dir_d   = x_dir_q;
    y_dir_d   = y_dir_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    srv_x_d   = srv_x_q;
    srv_y_d   = srv_y_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.serve_req) begin
          state_d = SERVE;
          step_d  = (bus.speed_sel == '0) ? SPEED_W'(1) : bus.speed_sel;
          cnt_d   = '0;
          x_dir_d = srv_x_q;
          y_dir_d = srv_y_q;
          srv_y_d = ~srv_y_q;
        end
      end
      SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (bus.frame_tick) begin
          x_dir_d = x_nd;
          y_d     = y_np;
          y_dir_d = y_nd;
          // A miss keeps x where it was; next serve heads toward the conceding side.
          if (x_exit) begin
            state_d = OUT;
            if (x_nd) begin
              score_l_d = 1'b1;
              srv_x_d   = 1'b1;
            end else begin
              score_r_d = 1'b1;
              srv_x_d   = 1'b0;
            end
          end else begin
            x_d = x_np;
          end
        end
      end
      OUT: begin
        state_d = IDLE;
        x_d     = XC;
        y_d     = YC;
      end
      default: state_d = IDLE;
    endcase
    in_play_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= XC;
      y_q       <= YC;
      x_dir_q   <= 1'b1;
      y_dir_q   <= 1'b1;
      step_q    <= SPEED_W'(1);
      cnt_q     <= '0;
      srv_x_q   <= 1'b1;
      srv_y_q   <= 1'b1;
      in_play_q <= 1'b0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x_dir_q   <= x_dir_d;
      y_dir_q   <= y_dir_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      srv_x_q   <= srv_x_d;
      srv_y_q   <= srv_y_d;
      in_play_q <= in_play_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign bus.ball_x  = x_q;
  assign bus.ball_y  = y_q;
  assign bus.x_dir   = x_dir_q;
  assign bus.y_dir   = y_dir_q;
  assign bus.in_play = in_play_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;

endmodule
